// File: rtl/fp_acc_16.sv
// FP16 accumulator: acc <= acc + in_data through an IDLE/ALIGN/ADD/NORM/DONE pipeline FSM.
// Overflow handling is selected by FP_ACC_SAT_EN (defined: saturate to max finite, undefined: infinity).
module fp_acc_16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        clear,
    output logic        in_ready,
    output logic [15:0] acc,
    output logic        out_valid,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

`ifdef FP_ACC_SAT_EN
    localparam logic [14:0] OVF_MAG = 15'h7BFF;
`else
    localparam logic [14:0] OVF_MAG = 15'h7C00;
`endif

    state_t      state_reg;
    logic [15:0] op_a_reg;
    logic [15:0] op_b_reg;
    logic [10:0] big_sig_reg;
    logic [10:0] small_sig_reg;
    logic [11:0] sum_reg;
    logic [5:0]  exp_reg;
    logic        sign_reg;
    logic        sub_reg;
    logic [15:0] res_reg;

    // Alignment datapath, evaluated from the latched operands
    logic        a_zero;
    logic        b_zero;
    logic        a_ge;
    logic [15:0] big_op;
    logic [15:0] small_op;
    logic [4:0]  exp_diff;
    logic [10:0] small_shifted;
    logic [15:0] shortcut_res;
    logic [11:0] sum_next;
    logic [5:0]  exp_inc;
    logic [5:0]  exp_dec;

    function automatic logic [15:0] pack(input logic s, input logic [5:0] e, input logic [9:0] f);
        logic [15:0] r;
        if (e > 6'd30) begin
            r = {s, OVF_MAG};
        end else begin
            r = {s, e[4:0], f};
        end
        return r;
    endfunction

    always_comb begin
        a_zero   = (op_a_reg[14:10] == 5'd0);
        b_zero   = (op_b_reg[14:10] == 5'd0);
        // Exponent sits above the fraction, so an unsigned magnitude compare orders correctly
        a_ge     = (op_a_reg[14:0] >= op_b_reg[14:0]);
        big_op   = a_ge ? op_a_reg : op_b_reg;
        small_op = a_ge ? op_b_reg : op_a_reg;
        exp_diff = big_op[14:10] - small_op[14:10];
        if (exp_diff >= 5'd11) begin
            small_shifted = 11'd0;
        end else begin
            small_shifted = {1'b1, small_op[9:0]} >> exp_diff;
        end
        if (a_zero && b_zero) begin
            shortcut_res = 16'h0000;
        end else if (a_zero) begin
            shortcut_res = op_b_reg;
        end else begin
            shortcut_res = op_a_reg;
        end
        if (sub_reg) begin
            sum_next = {1'b0, big_sig_reg} - {1'b0, small_sig_reg};
        end else begin
            sum_next = {1'b0, big_sig_reg} + {1'b0, small_sig_reg};
        end
        exp_inc = exp_reg + 6'd1;
        exp_dec = exp_reg - 6'd1;
    end

    assign in_ready = (state_reg == IDLE) && !clear;
    assign busy     = (state_reg != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            acc           <= 16'h0000;
            out_valid     <= 1'b0;
            op_a_reg      <= 16'h0000;
            op_b_reg      <= 16'h0000;
            big_sig_reg   <= 11'd0;
            small_sig_reg <= 11'd0;
            sum_reg       <= 12'd0;
            exp_reg       <= 6'd0;
            sign_reg      <= 1'b0;
            sub_reg       <= 1'b0;
            res_reg       <= 16'h0000;
        end else begin
            out_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (clear) begin
                        acc <= 16'h0000;
                    end else if (in_valid) begin
                        op_a_reg  <= acc;
                        op_b_reg  <= in_data;
                        state_reg <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (a_zero || b_zero) begin
                        res_reg   <= shortcut_res;
                        state_reg <= DONE;
                    end else begin
                        big_sig_reg   <= {1'b1, big_op[9:0]};
                        small_sig_reg <= small_shifted;
                        exp_reg       <= {1'b0, big_op[14:10]};
                        sign_reg      <= big_op[15];
                        sub_reg       <= big_op[15] ^ small_op[15];
                        state_reg     <= ADD;
                    end
                end
                ADD: begin
                    sum_reg <= sum_next;
                    if (sum_next == 12'd0) begin
                        res_reg   <= 16'h0000;
                        state_reg <= DONE;
                    end else begin
                        state_reg <= NORM;
                    end
                end
                NORM: begin
                    if (sum_reg[11]) begin
                        // A carry-out leaves bit 10 set after one right shift, so finish now
                        sum_reg   <= sum_reg >> 1;
                        exp_reg   <= exp_inc;
                        res_reg   <= pack(sign_reg, exp_inc, sum_reg[10:1]);
                        state_reg <= DONE;
                    end else if (!sum_reg[10]) begin
                        sum_reg <= sum_reg << 1;
                        exp_reg <= exp_dec;
                        if (exp_dec == 6'd0) begin
                            res_reg   <= 16'h0000;
                            state_reg <= DONE;
                        end
                    end else begin
                        res_reg   <= pack(sign_reg, exp_reg, sum_reg[9:0]);
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    acc       <= res_reg;
                    out_valid <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_acc_16.sv
// Directed bench for fp_acc_16: a table of chained accumulations plus clear, mid-op reset and overflow sequences.
module tb_fp_acc_16;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic        clear;
    logic        in_ready;
    logic [15:0] acc;
    logic        out_valid;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    fp_acc_16 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clear     (clear),
        .in_ready  (in_ready),
        .acc       (acc),
        .out_valid (out_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [15:0] exp_acc;
        int          lat;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Issue one addend and return the cycle of out_valid (-1 if none within the bound)
    task automatic do_op(input logic [15:0] d, output int lat);
        lat = -1;
        @(negedge clk);
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    int lat;

    initial begin
        vecs[0]  = '{16'h3C00, 16'h3C00, 2};
        vecs[1]  = '{16'h3C00, 16'h4000, 4};
        vecs[2]  = '{16'hBC00, 16'h3C00, 5};
        vecs[3]  = '{16'hBC00, 16'h0000, 3};
        vecs[4]  = '{16'h4200, 16'h4200, 2};
        vecs[5]  = '{16'h3800, 16'h4300, 4};
        vecs[6]  = '{16'hC300, 16'h0000, 3};
        vecs[7]  = '{16'h0001, 16'h0000, 2};
        vecs[8]  = '{16'h3C01, 16'h3C01, 2};
        vecs[9]  = '{16'hBC00, 16'h1400, 14};
        vecs[10] = '{16'h6400, 16'h6400, 4};
        vecs[11] = '{16'h3C00, 16'h6401, 4};
        vecs[12] = '{16'hE401, 16'h0000, 3};
        vecs[13] = '{16'h0401, 16'h0401, 2};
        vecs[14] = '{16'h8400, 16'h0000, 4};
        vecs[15] = '{16'h3C00, 16'h3C00, 2};
        vecs[16] = '{16'hC000, 16'hBC00, 5};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 16'h0000;
        clear    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_acc", {16'd0, acc}, 32'h0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 17; i++) begin
            do_op(vecs[i].data, lat);
            check($sformatf("latency[%0d]", i), lat, vecs[i].lat);
            check($sformatf("acc[%0d]", i), {16'd0, acc}, {16'd0, vecs[i].exp_acc});
            $display("vec %0d: add %h -> acc %h, out_valid at cycle %0d", i, vecs[i].data, acc, lat);
            @(posedge clk);
            #1;
            check($sformatf("pulse_width[%0d]", i), {31'd0, out_valid}, 32'd0);
        end

        // clear together with in_valid while idle: clear wins, nothing is accepted
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h3C00;
        #1;
        check("clear_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("clear_acc", {16'd0, acc}, 32'h0);
        check("clear_busy", {31'd0, busy}, 32'd0);
        clear    = 1'b0;
        in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat = k;
        end
        check("clear_no_out_valid", lat, -1);
        $display("clear: acc %h", acc);

        // reset while the FSM is left-shifting in NORM
        do_op(16'h3C01, lat);
        check("pre_reset_acc", {16'd0, acc}, 32'h3C01);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'hBC00;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("norm_busy_before_reset", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("midop_reset_acc", {16'd0, acc}, 32'h0);
        check("midop_reset_busy", {31'd0, busy}, 32'd0);
        check("midop_reset_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midop_in_ready_after", {31'd0, in_ready}, 32'd1);
        lat = -1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat = k;
        end
        check("midop_no_out_valid", lat, -1);
        $display("reset in NORM: acc %h busy %b", acc, busy);

        // overflow: max finite + max finite
        do_op(16'h7BFF, lat);
        check("ovf_load_acc", {16'd0, acc}, 32'h7BFF);
        do_op(16'h7BFF, lat);
        check("ovf_latency", lat, 4);
`ifdef FP_ACC_SAT_EN
        check("ovf_acc", {16'd0, acc}, 32'h7BFF);
`else
        check("ovf_acc", {16'd0, acc}, 32'h7C00);
`endif
        $display("overflow: acc %h at cycle %0d", acc, lat);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
